// File: rtl/apu_pkg.sv
// Shared constants and helpers for the APU frame sequencer.
package apu_pkg;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  localparam logic [2:0] LAST_STEP_4 = 3'd3;
  localparam logic [2:0] LAST_STEP_5 = 3'd4;

  // Pulse masks, bit i = pulse on step i
  localparam logic [4:0] QTR_MASK_4  = 5'b01111;
  localparam logic [4:0] HALF_MASK_4 = 5'b01010;
  localparam logic [4:0] QTR_MASK_5  = 5'b10111;
  localparam logic [4:0] HALF_MASK_5 = 5'b10010;

  function automatic logic [2:0] next_step(input logic [2:0] cur, input logic mode);
    logic [2:0] last;
    last = (mode == MODE_5STEP) ? LAST_STEP_5 : LAST_STEP_4;
    return (cur >= last) ? 3'd0 : cur + 3'd1;
  endfunction

  function automatic logic [4:0] qtr_mask(input logic mode);
    return (mode == MODE_5STEP) ? QTR_MASK_5 : QTR_MASK_4;
  endfunction

  function automatic logic [4:0] half_mask(input logic mode);
    return (mode == MODE_5STEP) ? HALF_MASK_5 : HALF_MASK_4;
  endfunction

endpackage

// File: rtl/apu_frame_divider.sv
// Prescaler for the frame sequencer: counts 0..ClkDiv-1, tick_o marks the wrap value.
module apu_frame_divider #(
  parameter int unsigned ClkDiv = 7457
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] Last = 16'(ClkDiv - 1);

  logic [15:0] cnt_q, cnt_d;

  // Next count: synchronous clear has priority over counting
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || (cnt_q == Last)) begin
      cnt_d = 16'd0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == Last);

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: quarter/half-frame enables, step index and frame IRQ flag.
// Optional build macro APU_FRAME_IRQ_EN enables the inhibit bit, IRQ flag and irq_ack;
// without it frame_irq is tied low and sequencing is unchanged.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 7457
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_data,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq,
  output logic [2:0] step
);

  logic       tick;
  logic       boundary;
  logic       mode_q, mode_d;
  logic [2:0] step_q, step_d;
  logic       adv_q, adv_d;
  logic       en240_q, en240_d;
  logic       en120_q, en120_d;
  logic [4:0] qtr_m, half_m;
  logic       unused_cfg;

  apu_frame_divider #(
    .ClkDiv (CLK_DIV)
  ) u_div (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (cfg_wr),
    .tick_o  (tick)
  );

  // A write restarts the frame, so it swallows a coincident boundary
  assign boundary = tick & ~cfg_wr;

  // Next-state for mode, step and pulse registers
  always_comb begin
    mode_d  = mode_q;
    step_d  = step_q;
    adv_d   = 1'b0;
    en240_d = 1'b0;
    en120_d = 1'b0;
    qtr_m   = qtr_mask(mode_q);
    half_m  = half_mask(mode_q);
    if (cfg_wr) begin
      mode_d = cfg_data[7];
      step_d = 3'd0;
      // Entering 5-step mode clocks the units immediately
      if (cfg_data[7] == MODE_5STEP) begin
        en240_d = 1'b1;
        en120_d = 1'b1;
      end
    end else begin
      // Step advances the cycle after its pulse so step reads the pulsing step
      if (adv_q) begin
        step_d = next_step(step_q, mode_q);
      end
      if (boundary) begin
        en240_d = qtr_m[step_q];
        en120_d = half_m[step_q];
        adv_d   = 1'b1;
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_4STEP;
      step_q  <= 3'd0;
      adv_q   <= 1'b0;
      en240_q <= 1'b0;
      en120_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      adv_q   <= adv_d;
      en240_q <= en240_d;
      en120_q <= en120_d;
    end
  end

  assign enable_240hz = en240_q;
  assign enable_120hz = en120_q;
  assign step         = step_q;

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;
  logic irq_set;

  assign irq_set = boundary && (mode_q == MODE_4STEP) && (step_q == LAST_STEP_4) && !inhibit_q;

  // IRQ flag: inhibit-write clear beats set, set beats acknowledge
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (irq_ack) begin
      irq_d = 1'b0;
    end
    if (irq_set) begin
      irq_d = 1'b1;
    end
    if (cfg_wr) begin
      inhibit_d = cfg_data[6];
      if (cfg_data[6]) begin
        irq_d = 1'b0;
      end
    end
  end

  // IRQ flag and inhibit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign frame_irq  = irq_q;
  assign unused_cfg = ^cfg_data[5:0];
`else
  assign frame_irq  = 1'b0;
  assign unused_cfg = ^{cfg_data[6:0], irq_ack};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer with CLK_DIV=4.
module tb_apu_frame_sequencer;

  localparam int D = 4;
`ifdef APU_FRAME_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       irq_ack = 1'b0;
  logic       enable_240hz, enable_120hz, frame_irq;
  logic [2:0] step;

  always #5 clk = ~clk;

  apu_frame_sequencer #(
    .CLK_DIV (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_data     (cfg_data),
    .irq_ack      (irq_ack),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq),
    .step         (step)
  );

  typedef struct packed {
    logic       e240;
    logic       e120;
    logic       irq;
    logic [2:0] stp;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: t = clk edges since the frame was last restarted
  int   t = 0;
  logic m_mode = 1'b0;
  logic m_inh = 1'b0;
  logic m_irq = 1'b0;

  function automatic exp_t dut_out();
    exp_t a;
    a.e240 = enable_240hz;
    a.e120 = enable_120hz;
    a.irq  = frame_irq;
    a.stp  = step;
    return a;
  endfunction

  function automatic void check(input string name, input exp_t act, input exp_t want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got e240=%b e120=%b irq=%b step=%0d, want e240=%b e120=%b irq=%b step=%0d",
               name, $time, act.e240, act.e120, act.irq, act.stp,
               want.e240, want.e120, want.irq, want.stp);
    end
  endfunction

  function automatic int nsteps();
    return m_mode ? 5 : 4;
  endfunction

  function automatic bit next_is_boundary();
    return ((t + 1) % D) == 0;
  endfunction

  function automatic int next_boundary_step();
    return ((t + 1) / D - 1) % nsteps();
  endfunction

  // Advance the model across one clock edge with the given inputs
  task automatic model_edge(input logic rst, input logic wr, input logic [7:0] data,
                            input logic ack);
    exp_t e;
    int   s;
    bit   set_irq;
    e = '0;
    set_irq = 1'b0;
    if (!rst) begin
      t = 0; m_mode = 1'b0; m_inh = 1'b0; m_irq = 1'b0;
    end else if (wr) begin
      t = 0;
      m_mode = data[7];
      if (IrqEn) begin
        if (ack) m_irq = 1'b0;
        m_inh = data[6];
        if (m_inh) m_irq = 1'b0;
      end
      e.e240 = m_mode;
      e.e120 = m_mode;
      e.irq  = m_irq;
    end else begin
      t++;
      if (t % D == 0) begin
        s = (t / D - 1) % nsteps();
        if (!m_mode) begin
          e.e240  = 1'b1;
          e.e120  = (s == 1) || (s == 3);
          set_irq = (s == 3) && !m_inh && IrqEn;
        end else begin
          e.e240 = (s != 3);
          e.e120 = (s == 1) || (s == 4);
        end
      end
      if (set_irq) m_irq = 1'b1;
      else if (ack && IrqEn) m_irq = 1'b0;
      e.irq = m_irq;
      e.stp = 3'(((t - 1) / D) % nsteps());
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic wr, input logic [7:0] data, input logic ack);
    @(negedge clk);
    rst_n = rst; cfg_wr = wr; cfg_data = data; irq_ack = ack;
    model_edge(rst, wr, data, ack);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Idle until the next edge is a boundary (optionally of a given step); bounded
  task automatic wait_boundary(input int want_step, input string name);
    int k;
    k = 0;
    while (!(next_is_boundary() && (want_step < 0 || next_boundary_step() == want_step))
           && k < 100) begin
      idle(1);
      k++;
    end
    if (k >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: boundary not reached within 100 cycles", name);
    end
  endtask

  // Monitor: compare DUT outputs after every edge with the scoreboard head
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("outputs", dut_out(), want);
      end
    end
  end

  initial begin
    exp_t zero;
    int   k;
    zero = '0;

    // 1: reset, then free-running 4-step frame
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    idle(20);

    // 2: switch to 5-step, immediate clock, 20-clk frames
    drive(1'b1, 1'b1, 8'h80, 1'b0);
    idle(45);

    // 3: raise IRQ in 4-step, then clear it with inhibit
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    idle(17);
    drive(1'b1, 1'b1, 8'h40, 1'b0);
    idle(48);

    // 4: ack coincident with set, then ack one cycle later
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    wait_boundary(3, "ack_wait");
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    idle(3);

    // 5: write on the prescaler wrap cycle
    wait_boundary(-1, "wrap_wait");
    drive(1'b1, 1'b1, 8'h00, 1'b0);
    idle(6);

    // 6: reset mid-frame while the step-2 pulse is showing
    k = 0;
    while (!(last_exp.e240 && last_exp.stp == 3'd2) && k < 100) begin
      idle(1);
      k++;
    end
    if (k >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL step2_wait: step-2 pulse not reached within 100 cycles");
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_out(), zero);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    idle(10);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic r, w, a;
      r = ($urandom_range(0, 299) != 0);
      w = ($urandom_range(0, 24) == 0);
      a = ($urandom_range(0, 5) == 0);
      drive(r, w, 8'($urandom), a);
    end
    idle(2);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
